// File: rtl/uart_pkg.sv
// Shared UART definitions: feeder FSM state encoding and default bit timing.
package uart_pkg;

  // Default baud divider shared by uart_tx, uart_rx and the feeder bench
  localparam int unsigned CLKS_PER_BIT = 87;

  // Feeder FSM state encoding (2 bits)
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with registered occupancy count; synchronous active-high reset.
// Writes while full and reads while empty are ignored.
module uart_byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  assign dout  = mem[rd_ptr];

  // Storage array; contents need no reset, only the pointers do
  always_ff @(posedge i_Clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte-buffering front end for uart_tx: FIFO-buffers producer bytes and hands
// them to uart_tx one at a time, pacing on uart_tx Active/Done.
// Optional feature: define FEEDER_GAP_EN to insert GAP_CLKS idle cycles after
// every Done before the next byte is issued.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned GAP_CLKS = 87
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_Wr_DV,
  input  logic [7:0]             i_Wr_Byte,
  output logic                   o_Wr_Ready,
  output logic                   o_Tx_DV,
  output logic [7:0]             o_Tx_Byte,
  input  logic                   i_Tx_Active,
  input  logic                   i_Tx_Done,
  output logic [$clog2(DEPTH):0] o_Fifo_Count,
  output logic                   o_Busy,
  output logic                   o_Overflow
);

  // Reject unusable configurations at elaboration
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || GAP_CLKS < 1) begin : g_param_check
    $error("uart_tx_feeder: DEPTH must be a power of two >= 2 and GAP_CLKS >= 1");
  end

  feeder_state_t          state;
  logic [7:0]             fifo_dout;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;

`ifdef FEEDER_GAP_EN
  localparam int unsigned GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  logic [GAP_W-1:0] gap_cnt;
`endif

  // Head byte leaves the FIFO on the same edge it is loaded into o_Tx_Byte
  assign pop = (state == IDLE) && !fifo_empty && !i_Tx_Active;

  uart_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .wr_en (i_Wr_DV),
    .rd_en (pop),
    .din   (i_Wr_Byte),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Status outputs come straight from registered count and state
  assign o_Fifo_Count = fifo_count;
  assign o_Wr_Ready   = !fifo_full;
  assign o_Busy       = (state != IDLE) || !fifo_empty;

  // Sticky overflow: any write presented while full, cleared only by reset
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Overflow <= 1'b0;
    end else if (i_Wr_DV && fifo_full) begin
      o_Overflow <= 1'b1;
    end
  end

  // Issue FSM: one-cycle DV per byte, byte held until uart_tx reports Done
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state     <= IDLE;
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= 8'h00;
`ifdef FEEDER_GAP_EN
      gap_cnt   <= '0;
`endif
    end else begin
      o_Tx_DV <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            o_Tx_Byte <= fifo_dout;
            o_Tx_DV   <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (i_Tx_Done) begin
`ifdef FEEDER_GAP_EN
            gap_cnt <= '0;
            state   <= GAP;
`else
            state   <= IDLE;
`endif
          end
        end
`ifdef FEEDER_GAP_EN
        GAP: begin
          if (gap_cnt == GAP_W'(GAP_CLKS - 1)) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder with a behavioural uart_tx downstream.
// Expected serial frames are queued when bytes are written and checked as
// each frame finishes on the line.
module tb_uart_tx_feeder;
  import uart_pkg::*;

  localparam int unsigned DEPTH    = 16;
  localparam int unsigned GAP_CLKS = 87;
  localparam int unsigned CPB      = CLKS_PER_BIT;
  localparam int unsigned CW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_dv;
  logic [7:0]    wr_byte;
  logic          wr_ready;
  logic          tx_dv;
  logic [7:0]    tx_byte;
  logic          tx_active;
  logic          tx_done;
  logic [CW-1:0] fifo_count;
  logic          busy;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #50 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_feeder #(
    .DEPTH    (DEPTH),
    .GAP_CLKS (GAP_CLKS)
  ) dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_Wr_DV      (wr_dv),
    .i_Wr_Byte    (wr_byte),
    .o_Wr_Ready   (wr_ready),
    .o_Tx_DV      (tx_dv),
    .o_Tx_Byte    (tx_byte),
    .i_Tx_Active  (tx_active),
    .i_Tx_Done    (tx_done),
    .o_Fifo_Count (fifo_count),
    .o_Busy       (busy),
    .o_Overflow   (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  // Scoreboard of expected line frames, in transmit order
  logic [9:0] sb[$];

  // Behavioural uart_tx: start bit, 8 data bits LSB first, stop bit; not reset by the feeder
  logic       tx_busy  = 1'b0;
  logic       done_r   = 1'b0;
  logic [9:0] tx_shreg = '1;
  logic [9:0] rx_frame = '0;
  int         tx_bit   = 0;
  int         tx_cnt   = 0;
  int         frames   = 0;
  logic       tx_line;

  assign tx_active = tx_busy;
  assign tx_done   = done_r;
  assign tx_line   = tx_busy ? tx_shreg[tx_bit] : 1'b1;

  always @(posedge clk) begin
    done_r <= 1'b0;
    if (!tx_busy) begin
      if (tx_dv) begin
        tx_shreg <= {1'b1, tx_byte, 1'b0};
        tx_bit   <= 0;
        tx_cnt   <= 0;
        tx_busy  <= 1'b1;
      end
    end else begin
      if (tx_cnt == int'(CPB / 2)) rx_frame[tx_bit] <= tx_line;
      if (tx_cnt == int'(CPB - 1)) begin
        tx_cnt <= 0;
        if (tx_bit == 9) begin
          tx_busy <= 1'b0;
          done_r  <= 1'b1;
          frames++;
          if (sb.size() == 0) begin
            check("unexpected_frame", 32'(rx_frame), 32'h0);
          end else begin
            check("serial_frame", 32'(rx_frame), 32'(sb.pop_front()));
          end
        end else begin
          tx_bit <= tx_bit + 1;
        end
      end else begin
        tx_cnt <= tx_cnt + 1;
      end
    end
  end

  // Output monitor: DV pulse width, DV only into an idle uart, byte stability, peak count
  int   dv_pulses = 0;
  int   peak      = 0;
  logic dv_prev   = 1'b0;
  logic stable_en = 1'b1;

  always @(negedge clk) begin
    if (tx_dv === 1'b1) begin
      dv_pulses++;
      check("dv_width", 32'(dv_prev), 32'h0);
      check("dv_into_busy_uart", 32'(tx_busy), 32'h0);
    end
    dv_prev = (tx_dv === 1'b1);
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
    if (stable_en && tx_busy) check("tx_byte_stable", 32'(tx_byte), 32'(tx_shreg[8:1]));
  end

  task automatic wait_idle(input int budget);
    bit ok = 0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (!busy && !tx_busy) ok = 1;
    end
    check("wait_idle", 32'(ok), 32'h1);
  endtask

  task automatic wait_active(input int budget);
    bit ok = 0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (tx_busy) ok = 1;
    end
    check("wait_active", 32'(ok), 32'h1);
  endtask

  task automatic wait_done(input int budget);
    bit ok = 0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (tx_done) ok = 1;
    end
    check("wait_done", 32'(ok), 32'h1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int dv0;
    int f0;
    int d_cyc;
    int v_cyc;
    bit seen;

    vecs[0] = '{data: 8'hAB, frame: 10'h356};
    vecs[1] = '{data: 8'h00, frame: 10'h200};
    vecs[2] = '{data: 8'hFF, frame: 10'h3FE};
    vecs[3] = '{data: 8'h81, frame: 10'h302};

    rst = 1'b1; wr_dv = 1'b0; wr_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_dv",       32'(tx_dv),      32'h0);
    check("rst_byte",     32'(tx_byte),    32'h0);
    check("rst_count",    32'(fifo_count), 32'h0);
    check("rst_ready",    32'(wr_ready),   32'h1);
    check("rst_busy",     32'(busy),       32'h0);
    check("rst_overflow", 32'(overflow),   32'h0);
    rst = 1'b0;

    // Single bytes: DV one cycle after accept, one cycle wide, busy drops after Done
    for (int i = 0; i < 4; i++) begin
      wait_idle(100);
      wr_dv = 1'b1; wr_byte = vecs[i].data;
      sb.push_back(vecs[i].frame);
      @(negedge clk);
      wr_dv = 1'b0;
      check("single_count_after_accept", 32'(fifo_count), 32'h1);
      check("single_dv_not_yet",         32'(tx_dv),      32'h0);
      @(negedge clk);
      check("single_dv",      32'(tx_dv),      32'h1);
      check("single_byte",    32'(tx_byte),    32'(vecs[i].data));
      check("single_popped",  32'(fifo_count), 32'h0);
      check("single_busy",    32'(busy),       32'h1);
      @(negedge clk);
      check("single_dv_fall", 32'(tx_dv),      32'h0);
      wait_done(1200);
      @(negedge clk);
      check("single_busy_fall", 32'(busy), 32'h0);
    end

    // Back-to-back burst of four bytes
    wait_idle(100);
    dv0 = dv_pulses; f0 = frames; peak = 0;
    foreach (vecs[i]) begin end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = (i == 0) ? 8'h3F : (i == 1) ? 8'h00 : (i == 2) ? 8'hFF : 8'h5A;
      wr_dv = 1'b1; wr_byte = b;
      sb.push_back(frame_of(b));
      @(negedge clk);
    end
    wr_dv = 1'b0;
    wait_idle(5000);
    check("burst_dv_pulses", 32'(dv_pulses - dv0), 32'd4);
    check("burst_frames",    32'(frames - f0),     32'd4);
    check("burst_peak_3_4",  32'(peak >= 3 && peak <= 4), 32'h1);
    check("burst_count_end", 32'(fifo_count), 32'h0);
    check("burst_sb_empty",  32'(sb.size()),  32'h0);

    // Overflow: primer occupies uart, then DEPTH+1 writes
    f0 = frames;
    wr_dv = 1'b1; wr_byte = 8'hC3; sb.push_back(frame_of(8'hC3));
    @(negedge clk);
    wr_dv = 1'b0;
    wait_active(10);
    for (int k = 0; k <= int'(DEPTH); k++) begin
      if (k == int'(DEPTH)) begin
        check("ovf_ready_low_when_full", 32'(wr_ready),   32'h0);
        check("ovf_count_full",          32'(fifo_count), 32'(DEPTH));
        check("ovf_not_yet",             32'(overflow),   32'h0);
      end
      wr_dv = 1'b1; wr_byte = 8'h10 + 8'(k);
      if (k < int'(DEPTH)) sb.push_back(frame_of(8'h10 + 8'(k)));
      @(negedge clk);
    end
    wr_dv = 1'b0;
    check("ovf_flag",       32'(overflow),   32'h1);
    check("ovf_count_held", 32'(fifo_count), 32'(DEPTH));
    wait_idle(20000);
    check("ovf_frames",   32'(frames - f0), 32'(DEPTH + 1));
    check("ovf_sticky",   32'(overflow),    32'h1);
    check("ovf_sb_empty", 32'(sb.size()),   32'h0);

    // Reset mid-frame with five bytes queued
    f0 = frames;
    wr_dv = 1'b1; wr_byte = 8'h96; sb.push_back(frame_of(8'h96));
    @(negedge clk);
    wr_dv = 1'b0;
    wait_active(10);
    for (int k = 0; k < 5; k++) begin
      wr_dv = 1'b1; wr_byte = 8'hA0 + 8'(k);
      @(negedge clk);
    end
    wr_dv = 1'b0;
    check("rstmid_queued", 32'(fifo_count), 32'd5);
    repeat (200) @(negedge clk);
    stable_en = 1'b0;
    dv0 = dv_pulses;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_count",    32'(fifo_count), 32'h0);
    check("rstmid_dv",       32'(tx_dv),      32'h0);
    check("rstmid_overflow", 32'(overflow),   32'h0);
    check("rstmid_ready",    32'(wr_ready),   32'h1);
    check("rstmid_busy",     32'(busy),       32'h0);
    check("rstmid_inflight", 32'(tx_busy),    32'h1);
    wait_done(1000);
    repeat (20) @(negedge clk);
    check("rstmid_no_dv",    32'(dv_pulses - dv0), 32'h0);
    check("rstmid_frames",   32'(frames - f0),     32'h1);
    check("rstmid_sb_empty", 32'(sb.size()),       32'h0);
    stable_en = 1'b1;

    // Simultaneous write and pop at count DEPTH-1
    wait_idle(100);
    f0 = frames;
    wr_dv = 1'b1; wr_byte = 8'h11; sb.push_back(frame_of(8'h11));
    @(negedge clk);
    wr_dv = 1'b0;
    wait_active(10);
    for (int k = 0; k < int'(DEPTH) - 1; k++) begin
      wr_dv = 1'b1; wr_byte = 8'h40 + 8'(k);
      sb.push_back(frame_of(8'h40 + 8'(k)));
      @(negedge clk);
    end
    wr_dv = 1'b0;
    check("wrpop_count_before", 32'(fifo_count), 32'(DEPTH - 1));
    wait_done(1000);
    @(negedge clk);
    wr_dv = 1'b1; wr_byte = 8'hEE; sb.push_back(frame_of(8'hEE));
    @(negedge clk);
    wr_dv = 1'b0;
    check("wrpop_count_same", 32'(fifo_count), 32'(DEPTH - 1));
    check("wrpop_dv",         32'(tx_dv),      32'h1);
    check("wrpop_head",       32'(tx_byte),    32'h40);
    wait_idle(20000);
    check("wrpop_frames",   32'(frames - f0), 32'(DEPTH + 1));
    check("wrpop_sb_empty", 32'(sb.size()),   32'h0);

    // Done-to-next-DV spacing, from the edge the feeder sees Done to the DV edge
    wait_idle(100);
    for (int i = 0; i < 2; i++) begin
      wr_dv = 1'b1; wr_byte = 8'h5C + 8'(i);
      sb.push_back(frame_of(8'h5C + 8'(i)));
      @(negedge clk);
    end
    wr_dv = 1'b0;
    wait_done(1200);
    d_cyc = cyc;
    v_cyc = d_cyc;
    seen = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (tx_dv) begin seen = 1; v_cyc = cyc; end
    end
    check("gap_dv_seen", 32'(seen), 32'h1);
`ifdef FEEDER_GAP_EN
    check("gap_spacing", 32'(v_cyc - d_cyc - 1), 32'(GAP_CLKS + 1));
`else
    check("gap_spacing", 32'(v_cyc - d_cyc - 1), 32'd1);
`endif
    wait_idle(2000);
    check("gap_sb_empty", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
